mem_arbiter: RTL
================

# mem_arbiter

Single-port access arbiter in front of the 256-byte, 8-bit `mem` block. It shares the memory between the instruction-fetch unit (read-only) and the load/store unit (read/write). LSU requests win by fixed priority, and a starvation counter bounds how long fetch can be locked out. Grants are combinational in the request cycle, the memory is driven in that same cycle, and read data and write acknowledgements come back registered one cycle later.

## Interface
- STARVE_LIMIT, 4: maximum consecutive LSU grants while fetch is waiting; range 1..15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level-held until granted.
- if_addr  in  8  fetch byte address.
- if_flush  in  1  squash fetch: blocks the fetch grant this cycle and suppresses this cycle's if_rvalid.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid (one-cycle pulse).
- if_rdata  out  8  fetch read data.
- ls_req  in  1  LSU request, level-held until granted.
- ls_wr  in  1  LSU access type: 1 = write, 0 = read.
- ls_addr  in  8  LSU byte address.
- ls_wdata  in  8  LSU write data.
- ls_gnt  out  1  LSU request accepted this cycle (combinational).
- ls_rvalid  out  1  LSU read data valid (one-cycle pulse).
- ls_rdata  out  8  LSU read data.
- ls_wack  out  1  LSU write committed (one-cycle pulse).
- mem_enable  out  1  to memory `enable`.
- mem_wr  out  1  to memory `wr`.
- mem_addr  out  8  to memory `addr`.
- mem_data_in  out  8  to memory `data_in`.
- mem_data_out  in  8  from memory `data_out`; combinational read data.

## Operation
- **Grant logic (combinational):**
  - Fetch is eligible when `if_req & ~if_flush`.
  - `force_if = (starve_cnt == STARVE_LIMIT) & fetch eligible`.
  - `ls_gnt = ls_req & ~force_if & ~rst`.
  - `if_gnt = fetch eligible & ~ls_gnt & ~rst`.
  - At most one grant per cycle.
- **Memory drive:**
  - `mem_enable = if_gnt | ls_gnt`.
  - `mem_wr = ls_gnt & ls_wr`.
  - `mem_addr` takes the granted requester's address.
  - `mem_data_in = ls_wdata`.
  - When nothing is granted, `mem_enable = 0`, `mem_wr = 0`, and address/data are 0.
- **Response registers, loaded on the grant edge:**
  - Fetch grant: `if_rdata <= mem_data_out`, `if_rvalid <= 1`.
  - LSU read grant: `ls_rdata <= mem_data_out`, `ls_rvalid <= 1`.
  - LSU write grant: `ls_wack <= 1`.
  - In cycles with no matching grant, the valid/ack flops clear. Data registers hold their last value.
- **Visible if_rvalid:** equals the registered flag AND `~if_flush`. A flush therefore kills the in-flight fetch response in the same cycle.
- **Starvation counter (`starve_cnt`, 4 bits):**
  - Increments, saturating at STARVE_LIMIT, when `ls_gnt & if_req & ~if_flush`.
  - Clears to 0 when `if_gnt`, or when `if_req == 0`, or when `if_flush == 1`.
  - Holds otherwise.
- **Reset:** while `rst` is high, no grants and no memory access (`mem_enable = 0`). This protects the memory's load-on-reset behaviour.
- **No backpressure on responses:** requesters must accept the valid pulse in the cycle it appears.

## Timing
- Async reset values:
  - `if_rvalid`, `ls_rvalid`, `ls_wack` = 0.
  - `if_rdata`, `ls_rdata` = 8'h00.
  - `starve_cnt` = 0.
  - Combinational outputs go to 0 while `rst = 1`.
- Latency:
  - Grant in cycle N → rvalid/wack asserted for exactly cycle N+1.
  - A write is committed to memory at the end of cycle N, so an LSU read granted in N+1 to the same address returns the new data.
- Back-to-back: a grant is possible every cycle. A response in N+1 and a new grant in N+1 coexist.
- Simultaneous requests, `starve_cnt < STARVE_LIMIT`: LSU wins and the counter increments.
- Simultaneous requests, counter at the limit: fetch wins and the counter clears.
- Reset mid-operation: a pending response pulse is dropped, not delivered after reset release.
- First grant possible in the first cycle with `rst = 0`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle with `ls_req = 1` → all outputs 0 immediately. No `mem_enable` while `rst = 1`.
- **Fetch read:** preload mem[8'h10] = 8'hA5; `if_req = 1`, `if_addr = 8'h10` → `if_gnt = 1` in N; `if_rvalid = 1` and `if_rdata = 8'hA5` in N+1 only.
- **Write then read:** LSU write 8'h3C to 8'h20 in N, then LSU read of 8'h20 in N+1 → `ls_wack` in N+1; `ls_rvalid` with `ls_rdata = 8'h3C` in N+2.
- **Starvation:** `if_req` and `ls_req` both held, STARVE_LIMIT = 4 → `ls_gnt` for 4 cycles, then `if_gnt` on the 5th, then LSU again. Pattern repeats every 5 cycles.
- **Flush:** fetch granted in N, `if_flush = 1` in N+1 → no `if_rvalid` in N+1 and no `if_gnt` in N+1. An LSU request in N+1 is still granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing one 256x8 memory between instruction fetch (read-only)
// and the load/store unit. LSU has fixed priority; a starvation counter bounds fetch lockout.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       if_req,
    input  logic [7:0] if_addr,
    input  logic       if_flush,
    output logic       if_gnt,
    output logic       if_rvalid,
    output logic [7:0] if_rdata,

    input  logic       ls_req,
    input  logic       ls_wr,
    input  logic [7:0] ls_addr,
    input  logic [7:0] ls_wdata,
    output logic       ls_gnt,
    output logic       ls_rvalid,
    output logic [7:0] ls_rdata,
    output logic       ls_wack,

    output logic       mem_enable,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data_in,
    input  logic [7:0] mem_data_out
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       fetch_ok;
    logic       force_if;
    logic       if_rvalid_q;

    // Grants are gated by rst so the memory never sees an access during reset.
    assign fetch_ok = if_req & ~if_flush;
    assign force_if = (starve_cnt == LIMIT) & fetch_ok;
    assign ls_gnt   = ls_req & ~force_if & ~rst;
    assign if_gnt   = fetch_ok & ~ls_gnt & ~rst;

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 8'h00;
        mem_data_in = 8'h00;
        if (ls_gnt) begin
            mem_enable  = 1'b1;
            mem_wr      = ls_wr;
            mem_addr    = ls_addr;
            mem_data_in = ls_wdata;
        end else if (if_gnt) begin
            mem_enable  = 1'b1;
            mem_addr    = if_addr;
            mem_data_in = ls_wdata;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid_q <= 1'b0;
            ls_rvalid   <= 1'b0;
            ls_wack     <= 1'b0;
            if_rdata    <= 8'h00;
            ls_rdata    <= 8'h00;
        end else begin
            if_rvalid_q <= if_gnt;
            ls_rvalid   <= ls_gnt & ~ls_wr;
            ls_wack     <= ls_gnt & ls_wr;
            if (if_gnt)
                if_rdata <= mem_data_out;
            if (ls_gnt && !ls_wr)
                ls_rdata <= mem_data_out;
        end
    end

    // A flush squashes a fetch response already in flight.
    assign if_rvalid = if_rvalid_q & ~if_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt || !if_req || if_flush) begin
            starve_cnt <= 4'd0;
        end else if (ls_gnt) begin
            if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule
